// File: rtl/xif_mem_responder_if.sv
// Bundle of the XIF memory request/result channel and the OBI data-bus port.
// The slave modport is the responder's view and the master modport is the view of everything around it.
interface xif_mem_responder_if #(
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_MEM_WIDTH = 32
);
    // XIF memory request
    logic                     mem_valid;
    logic                     mem_ready;
    logic [X_ID_WIDTH-1:0]    mem_req_id;
    logic [31:0]              mem_req_addr;
    logic                     mem_req_we;
    logic [2:0]               mem_req_size;
    logic [X_MEM_WIDTH/8-1:0] mem_req_be;
    logic [X_MEM_WIDTH-1:0]   mem_req_wdata;
    logic                     mem_resp_exc;
    logic [5:0]               mem_resp_exccode;
    // XIF memory result
    logic                     mem_result_valid;
    logic [X_ID_WIDTH-1:0]    mem_result_id;
    logic [X_MEM_WIDTH-1:0]   mem_result_rdata;
    logic                     mem_result_err;
    // OBI data bus
    logic                     obi_req;
    logic                     obi_gnt;
    logic [31:0]              obi_addr;
    logic                     obi_we;
    logic [X_MEM_WIDTH/8-1:0] obi_be;
    logic [X_MEM_WIDTH-1:0]   obi_wdata;
    logic                     obi_rvalid;
    logic [X_MEM_WIDTH-1:0]   obi_rdata;
    logic                     obi_err;

    modport slave (
        input  mem_valid, mem_req_id, mem_req_addr, mem_req_we, mem_req_size,
               mem_req_be, mem_req_wdata,
        output mem_ready, mem_resp_exc, mem_resp_exccode,
        output mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err,
        output obi_req, obi_addr, obi_we, obi_be, obi_wdata,
        input  obi_gnt, obi_rvalid, obi_rdata, obi_err
    );

    modport master (
        output mem_valid, mem_req_id, mem_req_addr, mem_req_we, mem_req_size,
               mem_req_be, mem_req_wdata,
        input  mem_ready, mem_resp_exc, mem_resp_exccode,
        input  mem_result_valid, mem_result_id, mem_result_rdata, mem_result_err,
        input  obi_req, obi_addr, obi_we, obi_be, obi_wdata,
        output obi_gnt, obi_rvalid, obi_rdata, obi_err
    );
endinterface

// File: rtl/xif_mem_responder.sv
// Takes one XIF memory request, rejects it if it is misaligned, and otherwise performs it as a single OBI transaction.
// The outcome is reported as a one-cycle mem_result strobe. Only one request is outstanding at a time.
module xif_mem_responder #(
    parameter int unsigned X_ID_WIDTH     = 4,
    parameter int unsigned X_MEM_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    xif_mem_responder_if.slave  bus
);
    localparam int unsigned BE_W      = X_MEM_WIDTH / 8;
    localparam int unsigned CNT_W     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [31:0] ADDR_MASK = ~(32'(BE_W) - 32'd1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESULT} state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [X_ID_WIDTH-1:0]  id_q, id_d;
    logic [31:0]            addr_q, addr_d;
    logic                   we_q, we_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [X_MEM_WIDTH-1:0] wdata_q, wdata_d;
    logic [X_MEM_WIDTH-1:0] rdata_q, rdata_d;
    logic                   err_q, err_d;
    logic                   ready_q, ready_d;
    logic                   req_q, req_d;
    logic                   result_valid_q, result_valid_d;

    logic                   accept;
    logic                   misaligned;
    logic                   exc;
    logic [5:0]             exccode;

    always_comb begin
        accept     = bus.mem_valid && ready_q;
        misaligned = (bus.mem_req_size == 3'd1 && bus.mem_req_addr[0])
                  || (bus.mem_req_size == 3'd2 && bus.mem_req_addr[1:0] != 2'b00)
                  || (bus.mem_req_size > 3'd2);
        exc        = accept && misaligned;
        exccode    = exc ? (bus.mem_req_we ? 6'd6 : 6'd4) : 6'd0;

        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        addr_d  = addr_q;
        we_d    = we_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (accept && !misaligned) begin
                    id_d    = bus.mem_req_id;
                    addr_d  = bus.mem_req_addr & ADDR_MASK;
                    we_d    = bus.mem_req_we;
                    be_d    = bus.mem_req_be;
                    wdata_d = bus.mem_req_wdata;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.obi_gnt) begin
                    cnt_d   = '0;
                    state_d = WAIT_R;
                end
            end
            WAIT_R: begin
                cnt_d = cnt_q + CNT_W'(1);
                // rvalid takes priority over a timeout expiring in the same cycle
                if (bus.obi_rvalid) begin
                    rdata_d = we_q ? '0 : bus.obi_rdata;
                    err_d   = bus.obi_err;
                    state_d = RESULT;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2)) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESULT;
                end
            end
            RESULT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Handshake outputs are registered copies of the next-state decode
        ready_d        = (state_d == IDLE);
        req_d          = (state_d == REQ);
        result_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            id_q           <= '0;
            addr_q         <= '0;
            we_q           <= 1'b0;
            be_q           <= '0;
            wdata_q        <= '0;
            rdata_q        <= '0;
            err_q          <= 1'b0;
            ready_q        <= 1'b1;
            req_q          <= 1'b0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            id_q           <= id_d;
            addr_q         <= addr_d;
            we_q           <= we_d;
            be_q           <= be_d;
            wdata_q        <= wdata_d;
            rdata_q        <= rdata_d;
            err_q          <= err_d;
            ready_q        <= ready_d;
            req_q          <= req_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign bus.mem_ready        = ready_q;
    assign bus.mem_resp_exc     = exc;
    assign bus.mem_resp_exccode = exccode;
    assign bus.mem_result_valid = result_valid_q;
    assign bus.mem_result_id    = id_q;
    assign bus.mem_result_rdata = rdata_q;
    assign bus.mem_result_err   = err_q;
    assign bus.obi_req          = req_q;
    assign bus.obi_addr         = addr_q;
    assign bus.obi_we           = we_q;
    assign bus.obi_be           = be_q;
    assign bus.obi_wdata        = wdata_q;
endmodule

// File: doc/xif_mem_responder.md
Name: xif_mem_responder

Overview:
- CPU-side responder for the eXtension-interface memory channel.
- Accepts one coprocessor memory request (mem_valid/mem_ready) and checks its alignment.
- Performs the access as a single OBI data-bus transaction (req/gnt, then rvalid).
- Returns the outcome on the mem_result channel. It is the counterpart to the coprocessor's memory-request initiator and sits between the XIF port and the core's data-bus arbiter.

Parameters:
- X_ID_WIDTH, 4, width of the XIF instruction id.
- X_MEM_WIDTH, 32, data width of the memory channel and the OBI data bus.
- TIMEOUT_CYCLES, 64, maximum number of cycles from gnt to rvalid before a timeout error is reported; must be ≥ 2.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mem_valid_i  in  1  XIF memory request valid
- mem_ready_o  out  1  XIF memory request ready
- mem_req_id_i  in  X_ID_WIDTH  request id
- mem_req_addr_i  in  32  byte address
- mem_req_we_i  in  1  1 = store
- mem_req_size_i  in  3  log2 of byte count: 0 = byte, 1 = half, 2 = word
- mem_req_be_i  in  X_MEM_WIDTH/8  byte enables
- mem_req_wdata_i  in  X_MEM_WIDTH  store data
- mem_resp_exc_o  out  1  request rejected with exception (combinational)
- mem_resp_exccode_o  out  6  exception code
- mem_result_valid_o  out  1  result strobe, 1 cycle
- mem_result_id_o  out  X_ID_WIDTH  id of the completed request
- mem_result_rdata_o  out  X_MEM_WIDTH  load data (0 for stores)
- mem_result_err_o  out  1  bus error or timeout
- obi_req_o  out  1  OBI request
- obi_gnt_i  in  1  OBI grant
- obi_addr_o  out  32  word-aligned address
- obi_we_o  out  1  OBI write enable
- obi_be_o  out  X_MEM_WIDTH/8  OBI byte enables
- obi_wdata_o  out  X_MEM_WIDTH  OBI write data
- obi_rvalid_i  in  1  OBI response valid
- obi_rdata_i  in  X_MEM_WIDTH  OBI read data
- obi_err_i  in  1  OBI error

Behaviour:
- Clock and reset: clk_i is the clock; rst_ni is the asynchronous, active-low reset.
- Reset values:
  - state = IDLE, so mem_ready_o = 1.
  - All other outputs = 0.
  - Timeout counter = 0.
  - Captured request registers = 0.
- States: IDLE, REQ, WAIT_R, RESULT.
- mem_ready_o = (state == IDLE).
- A request is accepted on a cycle where mem_valid_i && mem_ready_o.
- Alignment check (combinational, valid only while mem_valid_i && mem_ready_o; otherwise 0):
  - misaligned = (size == 1 && addr[0]) || (size == 2 && addr[1:0] != 0) || size > 2.
  - mem_resp_exc_o = misaligned.
  - mem_resp_exccode_o = 6 for a misaligned store, 4 for a misaligned load, otherwise 0.
- IDLE:
  - Accept and misaligned: no bus transaction, no mem_result, stay in IDLE.
  - Accept and aligned:
    - Capture id, we, be, wdata.
    - Capture addr with bits [1:0] forced to 0 (for X_MEM_WIDTH = 32).
    - Next state REQ.
- REQ:
  - obi_req_o = 1; obi_addr_o, obi_we_o, obi_be_o and obi_wdata_o driven from the captured registers and held stable until gnt.
  - On obi_gnt_i: go to WAIT_R, obi_req_o drops the next cycle, counter cleared.
  - The request is never withdrawn before gnt, however many cycles that takes.
- WAIT_R:
  - Counter increments every cycle.
  - obi_rvalid_i: register rdata (forced to 0 when the captured we = 1) and err = obi_err_i; next state RESULT.
  - Counter reaches TIMEOUT_CYCLES-1 without rvalid: rdata = 0, err = 1; next state RESULT.
  - rvalid arriving in the same cycle as the timeout: rvalid wins and its data/err are used.
  - A late rvalid arriving after a timeout, in any state other than WAIT_R, is ignored.
- RESULT:
  - mem_result_valid_o = 1 for exactly one cycle, with id, rdata and err valid in that cycle.
  - Next state IDLE.
  - The result channel has no ready; the consumer must accept the result when it is presented.
- Latency for an aligned access with gnt and rvalid each arriving on their earliest cycle:
  - accept at cycle t, obi_req_o high at t+1, gnt at t+1, rvalid at t+2, mem_result_valid_o at t+3.
  - mem_ready_o high again at t+4.
- Only one request is ever outstanding.
- obi_gnt_i asserted outside REQ and obi_rvalid_i asserted outside WAIT_R are ignored.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; an OBI transaction in flight is abandoned and its response is ignored.

Test Plan:
- Aligned load: addr 0x1000_0004, size 2, we 0; gnt on the first REQ cycle; rvalid after 1 cycle with rdata 0xDEAD_BEEF → obi_addr 0x1000_0004, obi_we 0; mem_result_valid for 1 cycle with rdata 0xDEAD_BEEF, err 0, id echoed; result at accept+3.
- Store with gnt stall: addr 0x2000_0000, wdata 0x1234_5678, be 0xF; gnt held low 5 cycles → obi_req, obi_addr and obi_wdata stable for all 6 REQ cycles; result rdata 0, err 0; mem_ready low throughout.
- Misaligned: load with size 2, addr 0x…0002 → exc 1, exccode 4, in the same cycle as the accept; store with size 1, addr 0x…0001 → exc 1, exccode 6. In both cases obi_req never rises, no result is produced, and mem_ready stays 1.
- Bus error: load with rvalid and err 1 → result err 1, id correct.
- Timeout: TIMEOUT_CYCLES = 8, rvalid withheld → result err 1 with rdata 0 exactly 8 cycles after gnt; a late rvalid one cycle later produces no second result.
- Reset in WAIT_R: drop rst_ni for 1 cycle → all outputs 0 and mem_ready 1 once reset is released; a stale rvalid after release is ignored, and a new load then completes normally.
